wb_port_arbiter: RTL and testbench

Write-back port controller for the single-write-port register file. It arbitrates three write-back sources (ALU, load unit, mul/div unit) onto the one write port, round-robin, with a valid/ready handshake. After reset it first runs a clear sequence that zeroes registers 1..31, because the register file itself has no reset. It sits between the pipeline's write-back stage and the register file's regWriteAddr/dataToWrite/toWrite inputs.

---
 rtl/wb_port_arbiter_pkg.sv | 29 ++
 rtl/wb_port_arbiter_rr_arb3.sv | 31 +++
 rtl/wb_port_arbiter.sv | 98 +++++++++
 tb/tb_wb_port_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants, state encoding and write-tag struct for the write-back port arbiter.
package wb_port_arbiter_pkg;

  localparam int         WB_WORD_WIDTH  = 32;
  localparam int         WB_NUM_SRC     = 3;

  localparam logic [1:0] WB_SRC_ALU     = 2'd0;
  localparam logic [1:0] WB_SRC_LOAD    = 2'd1;
  localparam logic [1:0] WB_SRC_MULDIV  = 2'd2;
  localparam logic [1:0] WB_SRC_CLEAR   = 2'd3;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam logic [4:0] REG_LAST       = 5'd31;

  typedef enum logic {ST_CLEAR, ST_RUN} wb_state_e;

  // Everything about a registered write except its data (data width is a module parameter).
  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [1:0] id;
  } wb_wr_t;

  // Round-robin successor over the three real sources; the clear id never enters rotation.
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p >= WB_SRC_MULDIV) ? WB_SRC_ALU : p + 2'd1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_arb3.sv
// Combinational 3-way round-robin grant: first requester at ptr, ptr+1, ptr+2 (mod 3).
module rr_arb3
  import wb_port_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] idx
);

  logic [1:0] c0, c1, c2;

  always_comb begin
    c0  = (ptr > WB_SRC_MULDIV) ? WB_SRC_ALU : ptr;
    c1  = rr_next(c0);
    c2  = rr_next(c1);
    gnt = '0;
    idx = c0;
    if (req[c0]) begin
      gnt[c0] = 1'b1;
      idx     = c0;
    end else if (req[c1]) begin
      gnt[c1] = 1'b1;
      idx     = c1;
    end else if (req[c2]) begin
      gnt[c2] = 1'b1;
      idx     = c2;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: clears x1..x31 after reset, then round-robins ALU/load/muldiv
// onto the single register-file write port with a one-cycle registered write.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH     = WB_WORD_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              srcValid,
  input  logic [14:0]             srcAddr,
  input  logic [3*WORD_WIDTH-1:0] srcData,
  output logic [2:0]              srcReady,
  output logic                    initDone,
  output logic [4:0]              regWriteAddr,
  output logic [WORD_WIDTH-1:0]   dataToWrite,
  output logic                    toWrite,
  output logic [1:0]              grantId
);

  wb_state_e             state, state_nxt;
  logic [4:0]            clear_cnt;
  logic [1:0]            rr_ptr;
  logic [2:0]            gnt;
  logic [1:0]            gnt_idx;
  logic                  fire;
  logic [4:0]            sel_addr;
  logic [WORD_WIDTH-1:0] sel_data;
  wb_wr_t                wr_q;
  logic [WORD_WIDTH-1:0] wr_data;

  rr_arb3 u_arb (
    .req (srcValid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // initDone is registered one cycle after entering RUN, so gating on it keeps grants
  // off until the last clear write has already been presented.
  always_comb begin
    srcReady = (initDone && !rst) ? gnt : 3'b000;
    fire     = |srcReady;
  end

  always_comb begin
    sel_addr = srcAddr[4:0];
    sel_data = srcData[WORD_WIDTH-1:0];
    for (int i = 0; i < WB_NUM_SRC; i++) begin
      if (gnt_idx == i[1:0]) begin
        sel_addr = srcAddr[5*i +: 5];
        sel_data = srcData[WORD_WIDTH*i +: WORD_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clear_cnt == REG_LAST) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clear_cnt <= 5'd1;
      rr_ptr    <= WB_SRC_ALU;
      wr_q      <= '0;
      wr_data   <= '0;
      initDone  <= 1'b0;
    end else begin
      state    <= state_nxt;
      initDone <= (state == ST_RUN);
      if (state == ST_CLEAR) begin
        wr_q      <= '{we: 1'b1, addr: clear_cnt, id: WB_SRC_CLEAR};
        wr_data   <= '0;
        clear_cnt <= clear_cnt + 5'd1;
      end else if (fire) begin
        // $zero writes complete the handshake but never reach the register file.
        wr_q    <= '{we: (sel_addr != REG_ZERO), addr: sel_addr, id: gnt_idx};
        wr_data <= sel_data;
        rr_ptr  <= rr_next(gnt_idx);
      end else begin
        wr_q.we <= 1'b0;
      end
    end
  end

  assign toWrite      = wr_q.we;
  assign regWriteAddr = wr_q.addr;
  assign grantId      = wr_q.id;
  assign dataToWrite  = wr_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: driver predicts grants/writes, monitor checks the write port.
module tb_wb_port_arbiter;

  localparam int W   = 32;
  localparam int BIG = 1 << 30;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [2:0]     srcValid = '0;
  logic [14:0]    srcAddr  = '0;
  logic [3*W-1:0] srcData  = '0;
  logic [2:0]     srcReady;
  logic           initDone;
  logic [4:0]     regWriteAddr;
  logic [W-1:0]   dataToWrite;
  logic           toWrite;
  logic [1:0]     grantId;

  wb_port_arbiter #(.WORD_WIDTH(W), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .srcValid(srcValid), .srcAddr(srcAddr), .srcData(srcData),
    .srcReady(srcReady), .initDone(initDone), .regWriteAddr(regWriteAddr),
    .dataToWrite(dataToWrite), .toWrite(toWrite), .grantId(grantId)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    bit           we;
    logic [4:0]   addr;
    logic [W-1:0] data;
    logic [1:0]   id;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  bit   mon_en = 0;

  // Source-side state: a source keeps its request stable until it is granted.
  bit           pv[3];
  logic [4:0]   pa[3];
  logic [W-1:0] pd[3];
  bit           rst_req  = 1'b1;
  bit           rst_prev = 1'b1;
  int           rr = 0;
  int           ready_from = BIG;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missed_write", 64'(e.cyc), 64'(cyc));
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("toWrite", 64'(toWrite), 64'(e.we));
        chk("regWriteAddr", 64'(regWriteAddr), 64'(e.addr));
        chk("dataToWrite", 64'(dataToWrite), 64'(e.data));
        chk("grantId", 64'(grantId), 64'(e.id));
      end else begin
        chk("idle_toWrite", 64'(toWrite), 64'd0);
      end
    end
  end

  task automatic step();
    int           g;
    logic [2:0]   exp_rdy;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      srcValid[i]       = pv[i];
      srcAddr[5*i +: 5] = pa[i];
      srcData[W*i +: W] = pd[i];
    end
    rst = rst_req;
    #1;
    g = -1;
    if (!rst_req && cyc >= ready_from)
      for (int k = 0; k < 3; k++)
        if (g < 0 && pv[(rr + k) % 3]) g = (rr + k) % 3;
    exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
    chk("srcReady", 64'(srcReady), 64'(exp_rdy));
    chk("initDone", 64'(initDone), 64'(cyc >= ready_from));
    if (g >= 0) begin
      q.push_back('{cyc + 1, pa[g] != 5'd0, pa[g], pd[g], 2'(g)});
      rr    = (g + 1) % 3;
      pv[g] = 1'b0;
    end
    if (rst_req) begin
      ready_from = BIG;
      rr = 0;
      while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    end else if (rst_prev) begin
      for (int k = 1; k <= 31; k++) q.push_back('{cyc + k, 1'b1, 5'(k), '0, 2'd3});
      ready_from = cyc + 32;
    end
    rst_prev = rst_req;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic fill_contention();
    for (int i = 0; i < 3; i++)
      if (!pv[i]) begin
        pv[i] = 1'b1; pa[i] = 5'(8 + i); pd[i] = $urandom;
      end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin pv[i] = 0; pa[i] = '0; pd[i] = '0; end

    // reset for two cycles, then check every output is cleared
    rst_req = 1'b1;
    run(2);
    mon_en = 1'b1;
    chk("rst_toWrite", 64'(toWrite), 64'd0);
    chk("rst_addr", 64'(regWriteAddr), 64'd0);
    chk("rst_data", 64'(dataToWrite), 64'd0);
    chk("rst_grantId", 64'(grantId), 64'd0);
    chk("rst_srcReady", 64'(srcReady), 64'd0);
    chk("rst_initDone", 64'(initDone), 64'd0);

    // clear with all sources requesting, then continuous contention
    rst_req = 1'b0;
    for (int i = 0; i < 40; i++) begin fill_contention(); step(); end
    run(4);

    // single ALU write
    pv[0] = 1; pa[0] = 5'd5; pd[0] = 32'hDEADBEEF;
    run(3);

    // rotation: load granted, then ALU and muldiv compete -> muldiv first
    pv[1] = 1; pa[1] = 5'd12; pd[1] = $urandom;
    step();
    pv[0] = 1; pa[0] = 5'd3; pd[0] = $urandom;
    pv[2] = 1; pa[2] = 5'd4; pd[2] = $urandom;
    run(4);

    // $zero write is handshaken but dropped
    pv[2] = 1; pa[2] = 5'd0; pd[2] = 32'h1234;
    run(3);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++)
        if (!pv[i] && $urandom_range(1, 0) == 1) begin
          pv[i] = 1;
          pa[i] = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
          pd[i] = $urandom;
        end
      step();
    end
    run(4);

    // reset at clear cycle 10 restarts the sequence from x1
    rst_req = 1'b1; step();
    rst_req = 1'b0; step();
    run(9);
    rst_req = 1'b1; step();
    rst_req = 1'b0;
    run(36);

    // reset in RUN while ALU is requesting
    pv[0] = 1; pa[0] = 5'd7; pd[0] = $urandom;
    rst_req = 1'b1; step();
    rst_req = 1'b0;
    run(40);

    run(3);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
